// File: rtl/dual_port_memory_if.sv
// Bus bundle for dual_port_memory: data channel (read/write), instruction channel (read-only)
// and the sticky bounds error flag.
interface dual_port_memory_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_write;
   logic              d_read;
   logic              d_push;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_underflow;
   logic [ADDR_W-1:0] i_addr;
   logic              i_read;
   logic              i_push;
   logic [DATA_W-1:0] i_rdata;
   logic              i_valid;
   logic              i_underflow;
   logic              err;

   modport master (
      output d_addr, d_wdata, d_write, d_read, d_push,
      output i_addr, i_read, i_push,
      input  d_rdata, d_valid, d_underflow,
      input  i_rdata, i_valid, i_underflow, err
   );

   modport slave (
      input  d_addr, d_wdata, d_write, d_read, d_push,
      input  i_addr, i_read, i_push,
      output d_rdata, d_valid, d_underflow,
      output i_rdata, i_valid, i_underflow, err
   );
endinterface

// File: rtl/dual_port_memory.sv
// Shared word array with a data channel and an instruction channel, each with a read latch and a
// push stage. Optional bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN.
module dual_port_memory #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 1024
) (
   input logic              clk,
   input logic              rst_n,
   dual_port_memory_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DEPTH);

   typedef enum logic {StEmpty, StFull} latch_state_e;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IdxW-1:0]   d_idx, i_idx;
   logic              d_oob, i_oob, d_we;
   logic [DATA_W-1:0] d_word, i_word;

   latch_state_e      d_state_q, d_state_d, i_state_q, i_state_d;
   logic [DATA_W-1:0] d_latch_q, d_latch_d, i_latch_q, i_latch_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
   logic              d_valid_q, d_valid_d, i_valid_q, i_valid_d;
   logic              d_unf_q, d_unf_d, i_unf_q, i_unf_d;

   assign d_idx = bus.d_addr[IdxW-1:0];
   assign i_idx = bus.i_addr[IdxW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
   logic err_q, err_d;

   assign d_oob = (bus.d_addr >> IdxW) != '0;
   assign i_oob = (bus.i_addr >> IdxW) != '0;

   always_comb begin
      err_d = err_q;
      if ((bus.d_write || bus.d_read) && d_oob) err_d = 1'b1;
      if (bus.i_read && i_oob) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   // Upper address bits are deliberately dropped so addresses alias modulo DEPTH.
   logic unused_addr;
   assign unused_addr = ^{bus.d_addr, bus.i_addr};
   assign d_oob   = 1'b0;
   assign i_oob   = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign d_we = bus.d_write && !d_oob;

   // Write-first: a same-edge write to the read index is forwarded to either latch.
   assign d_word = d_oob ? '0 : (d_we ? bus.d_wdata : mem[d_idx]);
   assign i_word = i_oob ? '0 : ((d_we && (d_idx == i_idx)) ? bus.d_wdata : mem[i_idx]);

   always_ff @(posedge clk) begin
      if (d_we) mem[d_idx] <= bus.d_wdata;
   end

   always_comb begin
      d_state_d = d_state_q;
      d_latch_d = d_latch_q;
      d_rdata_d = d_rdata_q;
      d_valid_d = 1'b0;
      d_unf_d   = 1'b0;
      if (bus.d_push) begin
         if (d_state_q == StFull) begin
            d_rdata_d = d_latch_q;
            d_valid_d = 1'b1;
            d_state_d = StEmpty;
         end else begin
            d_unf_d = 1'b1;
         end
      end
      if (bus.d_read) begin
         d_latch_d = d_word;
         d_state_d = StFull;
      end
   end

   always_comb begin
      i_state_d = i_state_q;
      i_latch_d = i_latch_q;
      i_rdata_d = i_rdata_q;
      i_valid_d = 1'b0;
      i_unf_d   = 1'b0;
      if (bus.i_push) begin
         if (i_state_q == StFull) begin
            i_rdata_d = i_latch_q;
            i_valid_d = 1'b1;
            i_state_d = StEmpty;
         end else begin
            i_unf_d = 1'b1;
         end
      end
      if (bus.i_read) begin
         i_latch_d = i_word;
         i_state_d = StFull;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_state_q <= StEmpty;
         d_latch_q <= '0;
         d_rdata_q <= '0;
         d_valid_q <= 1'b0;
         d_unf_q   <= 1'b0;
         i_state_q <= StEmpty;
         i_latch_q <= '0;
         i_rdata_q <= '0;
         i_valid_q <= 1'b0;
         i_unf_q   <= 1'b0;
      end else begin
         d_state_q <= d_state_d;
         d_latch_q <= d_latch_d;
         d_rdata_q <= d_rdata_d;
         d_valid_q <= d_valid_d;
         d_unf_q   <= d_unf_d;
         i_state_q <= i_state_d;
         i_latch_q <= i_latch_d;
         i_rdata_q <= i_rdata_d;
         i_valid_q <= i_valid_d;
         i_unf_q   <= i_unf_d;
      end
   end

   assign bus.d_rdata     = d_rdata_q;
   assign bus.d_valid     = d_valid_q;
   assign bus.d_underflow = d_unf_q;
   assign bus.i_rdata     = i_rdata_q;
   assign bus.i_valid     = i_valid_q;
   assign bus.i_underflow = i_unf_q;
endmodule
